// File: rtl/rr_psel_reg_if.sv
// ---------------------------------------------------------------------------
// rr_psel_reg_if
// Bundles the request/grant signals of the round-robin multi-grant selector.
//
// Parameters:
//   WIDTH  number of request lines
//   REQS   maximum grants per cycle
//
// Signals (direction as seen by the selector, i.e. the slave modport):
//   en          in   evaluate a new selection this cycle
//   stall       in   hold grant outputs and pointer
//   req         in   WIDTH request vector
//   gnt         out  OR of all grant slots (registered)
//   gnt_bus     out  REQS one-hot slots, slot k = [(k+1)*WIDTH-1 -: WIDTH]
//   gnt_cnt     out  number of grants issued (registered)
//   ptr         out  current priority pointer
//   empty       out  combinational ~|req
//   gnt_idx     out  per-slot binary index     (only with RR_PSEL_GNT_IDX_EN)
//   gnt_idx_vld out  per-slot valid            (only with RR_PSEL_GNT_IDX_EN)
//
// Optional feature macro: RR_PSEL_GNT_IDX_EN
// ---------------------------------------------------------------------------
interface rr_psel_reg_if #(
  parameter int WIDTH = 16,
  parameter int REQS  = 3
);
  localparam int PTR_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(REQS + 1);

  logic                    en;
  logic                    stall;
  logic [WIDTH-1:0]        req;
  logic [WIDTH-1:0]        gnt;
  logic [WIDTH*REQS-1:0]   gnt_bus;
  logic [CNT_W-1:0]        gnt_cnt;
  logic [PTR_W-1:0]        ptr;
  logic                    empty;
`ifdef RR_PSEL_GNT_IDX_EN
  logic [REQS*PTR_W-1:0]   gnt_idx;
  logic [REQS-1:0]         gnt_idx_vld;
`endif

  modport master (
    output en, stall, req,
`ifdef RR_PSEL_GNT_IDX_EN
    input  gnt_idx, gnt_idx_vld,
`endif
    input  gnt, gnt_bus, gnt_cnt, ptr, empty
  );

  modport slave (
    input  en, stall, req,
`ifdef RR_PSEL_GNT_IDX_EN
    output gnt_idx, gnt_idx_vld,
`endif
    output gnt, gnt_bus, gnt_cnt, ptr, empty
  );
endinterface

// File: rtl/rr_psel_reg.sv
// ---------------------------------------------------------------------------
// rr_psel_reg
// Registered round-robin multi-grant priority selector. Each enabled cycle
// the first REQS set request bits, scanned from ptr upward with wrap-around,
// are placed into grant slots 0..REQS-1 and registered. The pointer then
// moves just past the last granted line. stall freezes every register.
//
// Ports:
//   clock    in  rising-edge clock
//   reset_n  in  asynchronous active-low reset
//   bus      rr_psel_reg_if.slave (en, stall, req in; gnt, gnt_bus,
//            gnt_cnt, ptr, empty out; gnt_idx/gnt_idx_vld when enabled)
//
// The interface instance must be built with the same WIDTH/REQS values.
//
// Optional feature macro: RR_PSEL_GNT_IDX_EN adds registered per-slot
// binary indices (gnt_idx) and per-slot valids (gnt_idx_vld).
// ---------------------------------------------------------------------------
module rr_psel_reg #(
  parameter  int WIDTH = 16,
  parameter  int REQS  = 3,
  localparam int PTR_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(REQS + 1)
) (
  input  logic            clock,
  input  logic            reset_n,
  rr_psel_reg_if.slave    bus
);

  // Registered state
  logic [WIDTH*REQS-1:0]         gnt_bus_reg;
  logic [WIDTH-1:0]              gnt_reg;
  logic [CNT_W-1:0]              gnt_cnt_reg;
  logic [PTR_W-1:0]              ptr_reg;

  // Combinational selection
  logic [REQS-1:0][WIDTH-1:0]    sel_bus_next;
  logic [WIDTH-1:0]              sel_or_next;
  logic [CNT_W-1:0]              sel_cnt_next;
  logic [PTR_W-1:0]              last_idx;
  logic [PTR_W-1:0]              ptr_next;
  int                            scan_cnt;
  int                            scan_idx;
`ifdef RR_PSEL_GNT_IDX_EN
  logic [REQS-1:0][PTR_W-1:0]    sel_idx_next;
  logic [REQS-1:0]               sel_vld_next;
  logic [REQS*PTR_W-1:0]         gnt_idx_reg;
  logic [REQS-1:0]               gnt_idx_vld_reg;
`endif

  // Walk all lines in scan order; each set request fills the next free
  // slot until REQS slots are taken. Slots therefore never share a bit.
  always_comb begin
    sel_bus_next = '0;
    sel_or_next  = '0;
    last_idx     = ptr_reg;
    scan_cnt     = 0;
    scan_idx     = 0;
`ifdef RR_PSEL_GNT_IDX_EN
    sel_idx_next = '0;
`endif
    for (int j = 0; j < WIDTH; j++) begin
      scan_idx = int'(ptr_reg) + j;
      if (scan_idx >= WIDTH) scan_idx = scan_idx - WIDTH;
      if (bus.req[scan_idx] && (scan_cnt < REQS)) begin
        sel_bus_next[scan_cnt][scan_idx] = 1'b1;
        sel_or_next[scan_idx]            = 1'b1;
        last_idx                         = PTR_W'(scan_idx);
`ifdef RR_PSEL_GNT_IDX_EN
        sel_idx_next[scan_cnt]           = PTR_W'(scan_idx);
`endif
        scan_cnt = scan_cnt + 1;
      end
    end
    sel_cnt_next = CNT_W'(scan_cnt);
    // Explicit wrap because WIDTH need not be a power of two.
    ptr_next = (int'(last_idx) == WIDTH - 1) ? '0 : last_idx + 1'b1;
  end

  // stall has priority over en; en=0 clears the grants but keeps ptr.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_bus_reg <= '0;
      gnt_reg     <= '0;
      gnt_cnt_reg <= '0;
      ptr_reg     <= '0;
    end else if (!bus.stall) begin
      if (bus.en) begin
        gnt_bus_reg <= sel_bus_next;
        gnt_reg     <= sel_or_next;
        gnt_cnt_reg <= sel_cnt_next;
        if (sel_cnt_next != '0) ptr_reg <= ptr_next;
      end else begin
        gnt_bus_reg <= '0;
        gnt_reg     <= '0;
        gnt_cnt_reg <= '0;
      end
    end
  end

`ifdef RR_PSEL_GNT_IDX_EN
  for (genvar gi = 0; gi < REQS; gi++) begin : g_vld
    assign sel_vld_next[gi] = |sel_bus_next[gi];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_idx_reg     <= '0;
      gnt_idx_vld_reg <= '0;
    end else if (!bus.stall) begin
      if (bus.en) begin
        gnt_idx_reg     <= sel_idx_next;
        gnt_idx_vld_reg <= sel_vld_next;
      end else begin
        gnt_idx_reg     <= '0;
        gnt_idx_vld_reg <= '0;
      end
    end
  end

  assign bus.gnt_idx     = gnt_idx_reg;
  assign bus.gnt_idx_vld = gnt_idx_vld_reg;
`endif

  assign bus.gnt_bus = gnt_bus_reg;
  assign bus.gnt     = gnt_reg;
  assign bus.gnt_cnt = gnt_cnt_reg;
  assign bus.ptr     = ptr_reg;
  assign bus.empty   = ~|bus.req;

endmodule

// File: doc/rr_psel_reg.md
Name: rr_psel_reg

Overview:
- Registered, round-robin, multi-grant priority selector for issue/dispatch select logic.
- Each enabled cycle it grants up to REQS of WIDTH request lines, scanning from a rotating priority pointer with wrap-around.
- Grants are registered (1-cycle latency), so the select stage is isolated from the wakeup/issue paths.
- The pointer advances past the last granted line for fairness. Stall holds the grants in place.

Parameters:
- REQS, 3: maximum grants per cycle; legal range 1 <= REQS <= WIDTH.
- WIDTH, 16: number of request lines; WIDTH >= 2, need not be a power of two.
- PTR_W, $clog2(WIDTH): pointer width (derived, not overridden).
- CNT_W, $clog2(REQS+1): grant count width (derived).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  evaluate a new selection this cycle.
- stall  in  1  downstream not ready; hold outputs and pointer.
- req  in  WIDTH  request vector; bit i = line i requesting.
- gnt  out  WIDTH  registered OR of all grant slots.
- gnt_bus  out  WIDTH*REQS  registered one-hot grant per slot; slot k is bits [(k+1)*WIDTH-1 -: WIDTH].
- gnt_cnt  out  CNT_W  registered number of grants issued (0..REQS).
- ptr  out  PTR_W  current priority pointer (debug/verification).
- empty  out  1  combinational ~|req.

Behaviour:
- Reset (reset_n=0, asynchronous): gnt, gnt_bus, gnt_cnt and ptr are 0 immediately.
  - empty keeps following req.
  - Outputs stay at 0 while reset_n=0. Normal operation starts on the first rising edge after deassertion.
- Selection (combinational, internal):
  - Scan order is ptr, ptr+1, …, WIDTH-1, 0, …, ptr-1.
  - The first REQS set bits of req in scan order go to slots 0..REQS-1 in order.
  - Unfilled slots are all-zero.
  - Each slot is one-hot or zero, and no two slots share a bit.
- Register update at the rising edge, priority stall > en:
  - stall=1: gnt, gnt_bus, gnt_cnt and ptr hold, regardless of en or req.
  - stall=0, en=1:
    - Load the selection into gnt_bus; gnt = OR of the slots; gnt_cnt = popcount(gnt).
    - If gnt_cnt > 0, ptr <= (index of the highest-filled slot's bit + 1) mod WIDTH, with wrap from WIDTH-1 to 0. Otherwise ptr holds.
  - stall=0, en=0: gnt, gnt_bus and gnt_cnt <= 0; ptr holds.
- Latency: req sampled at edge N appears on gnt/gnt_bus after edge N, i.e. 1 cycle.
- No combinational path from req to gnt, gnt_bus or gnt_cnt. empty is the only combinational output.
- req is not masked by grants still held in registers; the requester must drop a request once it is granted.
- popcount(req) < REQS: grant every requester; gnt_cnt equals popcount(req).
- popcount(req) = 0 with en=1: all grant outputs become 0, ptr unchanged, empty=1.
- REQS = WIDTH with all requests set: all lines granted; ptr returns to (ptr+WIDTH-1+1) mod WIDTH, i.e. it stays at ptr.

Optional Feature:
- Macro: RR_PSEL_GNT_IDX_EN.
- Defined: adds two registered outputs.
  - gnt_idx  out  REQS*PTR_W: binary index of each slot's granted line.
  - gnt_idx_vld  out  REQS: per-slot valid; equals |gnt_bus slot k.
  - Both follow the same stall/en/reset rules as gnt_bus. Reset value is 0.
  - gnt_idx for an invalid slot is 0.
- Undefined: these ports and their registers are absent. All other behaviour is identical.

Test Plan (WIDTH=8, REQS=3):
- Reset check: assert reset_n=0 mid-cycle with req=8'hFF and prior grants live -> gnt, gnt_bus, gnt_cnt and ptr go to 0 without a clock edge; empty=0.
- Rotation: req=8'hFF, en=1, stall=0 from ptr=0 for three cycles ->
  - cycle 1: gnt=8'h07, slots 0/1/2 = bits 0/1/2.
  - cycle 2: gnt=8'h38.
  - cycle 3: gnt=8'hC1 with slots bits 6/7/0; ptr=1.
  - gnt_cnt=3 each cycle.
- Sparse wrap: ptr=1, req=8'b0000_0101 -> slot0=bit2, slot1=bit0, slot2=0, gnt_cnt=2, ptr stays 1.
- Stall: stall=1 for 2 cycles while req changes to 8'hF0 -> gnt, gnt_bus, gnt_cnt and ptr unchanged. After stall=0, grants reflect 8'hF0 from the held ptr.
- Empty/disable:
  - req=0, en=1 -> empty=1, gnt=0, gnt_cnt=0, ptr unchanged.
  - en=0 with req=8'hFF -> outputs 0, ptr unchanged.
- RR_PSEL_GNT_IDX_EN defined, ptr=6, req=8'hC1 -> gnt_idx slots = 6, 7, 0; gnt_idx_vld=3'b111.
